// File: rtl/operand_issuer_if.sv
// Handshake and data bundle between the operand producer, the operand issuer
// and the multiplier control machine.
interface operand_issuer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic                   iWr_En;
    logic [WIDTH-1:0]       iData_A;
    logic [WIDTH-1:0]       iData_B;
    logic                   oFull;
    logic [$clog2(DEPTH):0] oCount;
    logic [WIDTH-1:0]       oData_A;
    logic [WIDTH-1:0]       oData_B;
    logic                   oValid_Data;
    logic                   iDone;
    logic                   oAck;
    logic                   oBusy;
    logic                   oOverflow;
    logic                   oTimeout;
    logic                   iClr_Err;

    modport master (
        output iWr_En, iData_A, iData_B, iDone, iClr_Err,
        input  oFull, oCount, oData_A, oData_B, oValid_Data, oAck, oBusy,
               oOverflow, oTimeout
    );

    modport slave (
        input  iWr_En, iData_A, iData_B, iDone, iClr_Err,
        output oFull, oCount, oData_A, oData_B, oValid_Data, oAck, oBusy,
               oOverflow, oTimeout
    );
endinterface

// File: rtl/operand_issuer.sv
// Operand-pair FIFO feeding a multiplier control machine through an
// ISSUE/WAIT/ACK handshake with a bounded wait and sticky error flags.
module operand_issuer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 80
) (
    input  logic            Clock,
    input  logic            Reset,
    operand_issuer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t             state_r;
    logic [2*WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]      head_r;
    logic [AW-1:0]      tail_r;
    logic [CW-1:0]      count_r;
    logic [CW-1:0]      count_next_s;
    logic               full_r;
    logic [TW-1:0]      wait_cnt_r;
    logic [WIDTH-1:0]   data_a_r;
    logic [WIDTH-1:0]   data_b_r;
    logic               valid_r;
    logic               ack_r;
    logic               busy_r;
    logic               overflow_r;
    logic               timeout_r;
    logic               push_s;
    logic               pop_s;
    logic               overflow_set_s;
    logic               timeout_set_s;

    // Fullness is judged on the registered flag, so a push in a pop cycle on a full FIFO is dropped.
    assign push_s         = bus.iWr_En & ~full_r;
    assign overflow_set_s = bus.iWr_En & full_r;
    assign pop_s          = (state_r == IDLE) && (count_r != {CW{1'b0}});
    assign timeout_set_s  = (state_r == WAIT) && !bus.iDone &&
                            (wait_cnt_r == TW'(TIMEOUT - 1));

    // Next occupancy from the push/pop pair of this cycle.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge Clock) begin
        if (push_s) begin
            mem_r[tail_r] <= {bus.iData_A, bus.iData_B};
        end
    end

    // FIFO pointers, occupancy and full flag.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            full_r  <= 1'b0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + AW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + AW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CW'(DEPTH));
        end
    end

    // Issue FSM with state-decoded strobes held in registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= {TW{1'b0}};
            data_a_r   <= {WIDTH{1'b0}};
            data_b_r   <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r <= 1'b0;
                    if (pop_s) begin
                        {data_a_r, data_b_r} <= mem_r[head_r];
                        state_r <= ISSUE;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ISSUE: begin
                    wait_cnt_r <= {TW{1'b0}};
                    state_r    <= WAIT;
                    valid_r    <= 1'b0;
                    ack_r      <= 1'b0;
                    busy_r     <= 1'b1;
                end
                WAIT: begin
                    wait_cnt_r <= wait_cnt_r + TW'(1);
                    valid_r    <= 1'b0;
                    busy_r     <= 1'b1;
                    // iDone takes precedence over the timeout in the same cycle.
                    if (bus.iDone || timeout_set_s) begin
                        state_r <= ACK;
                        ack_r   <= 1'b1;
                    end else begin
                        state_r <= WAIT;
                        ack_r   <= 1'b0;
                    end
                end
                ACK: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    ack_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    ack_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else if (bus.iClr_Err) begin
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end
            if (timeout_set_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign bus.oFull       = full_r;
    assign bus.oCount      = count_r;
    assign bus.oData_A     = data_a_r;
    assign bus.oData_B     = data_b_r;
    assign bus.oValid_Data = valid_r;
    assign bus.oAck        = ack_r;
    assign bus.oBusy       = busy_r;
    assign bus.oOverflow   = overflow_r;
    assign bus.oTimeout    = timeout_r;
endmodule

// File: tb/tb_operand_issuer.sv
// Directed bench for operand_issuer: each task drives one scenario and
// compares outputs against hand-computed values one cycle at a time.
module tb_operand_issuer;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    operand_issuer_if #(.WIDTH(32), .DEPTH(4)) bus ();

    operand_issuer #(.WIDTH(32), .DEPTH(4), .TIMEOUT(80)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (bus.oValid_Data !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", bus.oValid_Data); end
        tests_run++; if (bus.oAck !== 1'b0) begin tests_failed++; $display("FAIL rst_ack: got %b want 0", bus.oAck); end
        tests_run++; if (bus.oBusy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", bus.oBusy); end
        tests_run++; if (bus.oFull !== 1'b0) begin tests_failed++; $display("FAIL rst_full: got %b want 0", bus.oFull); end
        tests_run++; if (bus.oCount !== 3'd0) begin tests_failed++; $display("FAIL rst_count: got %0d want 0", bus.oCount); end
        tests_run++; if ({bus.oOverflow, bus.oTimeout} !== 2'b00) begin tests_failed++; $display("FAIL rst_flags: got %b want 00", {bus.oOverflow, bus.oTimeout}); end
        tests_run++; if ({bus.oData_A, bus.oData_B} !== 64'd0) begin tests_failed++; $display("FAIL rst_data: got %h want 0", {bus.oData_A, bus.oData_B}); end
        rst_n = 1'b1;
        tick();
        tests_run++; if (bus.oBusy !== 1'b0 || bus.oCount !== 3'd0) begin tests_failed++; $display("FAIL rst_release: busy %b count %0d want 0 0", bus.oBusy, bus.oCount); end
    endtask

    task automatic test_single();
        bus.iWr_En = 1'b1; bus.iData_A = 32'hFFFFFFFF; bus.iData_B = 32'hFFFFFFFF;
        tick();
        bus.iWr_En = 1'b0;
        tests_run++; if (bus.oCount !== 3'd1 || bus.oValid_Data !== 1'b0) begin tests_failed++; $display("FAIL single_queued: count %0d valid %b want 1 0", bus.oCount, bus.oValid_Data); end
        tick();
        tests_run++; if (bus.oValid_Data !== 1'b1) begin tests_failed++; $display("FAIL single_latency: valid %b want 1", bus.oValid_Data); end
        tests_run++; if (bus.oData_A !== 32'hFFFFFFFF || bus.oData_B !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL single_data: got %h %h want ffffffff ffffffff", bus.oData_A, bus.oData_B); end
        tests_run++; if (bus.oBusy !== 1'b1 || bus.oCount !== 3'd0) begin tests_failed++; $display("FAIL single_issue: busy %b count %0d want 1 0", bus.oBusy, bus.oCount); end
        tick();
        tests_run++; if (bus.oValid_Data !== 1'b0) begin tests_failed++; $display("FAIL single_strobe: valid %b want 0", bus.oValid_Data); end
        repeat (38) tick();
        bus.iDone = 1'b1;
        tick();
        bus.iDone = 1'b0;
        tests_run++; if (bus.oAck !== 1'b1 || bus.oValid_Data !== 1'b0) begin tests_failed++; $display("FAIL single_ack: ack %b valid %b want 1 0", bus.oAck, bus.oValid_Data); end
        tick();
        tests_run++; if (bus.oAck !== 1'b0 || bus.oBusy !== 1'b0 || bus.oCount !== 3'd0 || bus.oTimeout !== 1'b0) begin tests_failed++; $display("FAIL single_done: ack %b busy %b count %0d tmo %b want 0 0 0 0", bus.oAck, bus.oBusy, bus.oCount, bus.oTimeout); end
        tests_run++; if (bus.oData_A !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL single_hold: got %h want ffffffff", bus.oData_A); end
    endtask

    task automatic test_back_to_back();
        bus.iWr_En = 1'b1; bus.iData_A = 32'h99; bus.iData_B = 32'h99;
        tick();
        bus.iWr_En = 1'b0;
        tick();
        tick();
        for (int k = 1; k <= 5; k++) begin
            bus.iWr_En = 1'b1; bus.iData_A = 32'(k); bus.iData_B = 32'(k + 9);
            tick();
        end
        bus.iWr_En = 1'b0;
        tests_run++; if (bus.oCount !== 3'd4 || bus.oFull !== 1'b1) begin tests_failed++; $display("FAIL b2b_full: count %0d full %b want 4 1", bus.oCount, bus.oFull); end
        tests_run++; if (bus.oOverflow !== 1'b1) begin tests_failed++; $display("FAIL b2b_overflow: got %b want 1", bus.oOverflow); end
        for (int k = 1; k <= 4; k++) begin
            bus.iDone = 1'b1;
            tick();
            bus.iDone = 1'b0;
            tests_run++; if (bus.oAck !== 1'b1) begin tests_failed++; $display("FAIL b2b_ack%0d: got %b want 1", k, bus.oAck); end
            tick();
            tests_run++; if (bus.oValid_Data !== 1'b0 || bus.oAck !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle%0d: valid %b ack %b want 0 0", k, bus.oValid_Data, bus.oAck); end
            tick();
            tests_run++; if (bus.oValid_Data !== 1'b1 || bus.oData_A !== 32'(k) || bus.oData_B !== 32'(k + 9)) begin tests_failed++; $display("FAIL b2b_issue%0d: valid %b A %0d B %0d want 1 %0d %0d", k, bus.oValid_Data, bus.oData_A, bus.oData_B, k, k + 9); end
            tick();
        end
        bus.iDone = 1'b1;
        tick();
        bus.iDone = 1'b0;
        tick();
        tests_run++; if (bus.oCount !== 3'd0 || bus.oBusy !== 1'b0 || bus.oFull !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: count %0d busy %b full %b want 0 0 0", bus.oCount, bus.oBusy, bus.oFull); end
        bus.iClr_Err = 1'b1;
        tick();
        bus.iClr_Err = 1'b0;
        tests_run++; if (bus.oOverflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_clear: got %b want 0", bus.oOverflow); end
    endtask

    task automatic test_timeout();
        bus.iWr_En = 1'b1; bus.iData_A = 32'h7; bus.iData_B = 32'h8;
        tick();
        bus.iWr_En = 1'b0;
        tick();
        tick();
        repeat (79) tick();
        tests_run++; if (bus.oAck !== 1'b0 || bus.oTimeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_early: ack %b tmo %b want 0 0", bus.oAck, bus.oTimeout); end
        tick();
        tests_run++; if (bus.oAck !== 1'b1 || bus.oTimeout !== 1'b1) begin tests_failed++; $display("FAIL tmo_abort: ack %b tmo %b want 1 1", bus.oAck, bus.oTimeout); end
        tick();
        tests_run++; if (bus.oAck !== 1'b0 || bus.oTimeout !== 1'b1 || bus.oBusy !== 1'b0) begin tests_failed++; $display("FAIL tmo_sticky: ack %b tmo %b busy %b want 0 1 0", bus.oAck, bus.oTimeout, bus.oBusy); end
        bus.iClr_Err = 1'b1;
        tick();
        bus.iClr_Err = 1'b0;
        tests_run++; if (bus.oTimeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_clear: got %b want 0", bus.oTimeout); end
    endtask

    task automatic test_timeout_race();
        bus.iWr_En = 1'b1; bus.iData_A = 32'h21; bus.iData_B = 32'h22;
        tick();
        bus.iWr_En = 1'b0;
        tick();
        tick();
        repeat (79) tick();
        bus.iDone = 1'b1;
        tick();
        bus.iDone = 1'b0;
        tests_run++; if (bus.oAck !== 1'b1 || bus.oTimeout !== 1'b0) begin tests_failed++; $display("FAIL race_done_wins: ack %b tmo %b want 1 0", bus.oAck, bus.oTimeout); end
        tick();
    endtask

    task automatic test_done_ignored();
        bus.iDone = 1'b1;
        tick();
        bus.iDone = 1'b0;
        tests_run++; if (bus.oAck !== 1'b0 || bus.oBusy !== 1'b0 || bus.oValid_Data !== 1'b0) begin tests_failed++; $display("FAIL ign_idle: ack %b busy %b valid %b want 0 0 0", bus.oAck, bus.oBusy, bus.oValid_Data); end
        bus.iWr_En = 1'b1; bus.iData_A = 32'h31; bus.iData_B = 32'h32;
        tick();
        bus.iWr_En = 1'b0;
        tick();
        tests_run++; if (bus.oValid_Data !== 1'b1) begin tests_failed++; $display("FAIL ign_issue: valid %b want 1", bus.oValid_Data); end
        bus.iDone = 1'b1;
        tick();
        bus.iDone = 1'b0;
        tests_run++; if (bus.oAck !== 1'b0 || bus.oBusy !== 1'b1 || bus.oValid_Data !== 1'b0) begin tests_failed++; $display("FAIL ign_in_issue: ack %b busy %b valid %b want 0 1 0", bus.oAck, bus.oBusy, bus.oValid_Data); end
        tick();
        tests_run++; if (bus.oAck !== 1'b0) begin tests_failed++; $display("FAIL ign_still_wait: ack %b want 0", bus.oAck); end
        bus.iDone = 1'b1;
        tick();
        bus.iDone = 1'b0;
        tests_run++; if (bus.oAck !== 1'b1) begin tests_failed++; $display("FAIL ign_finish: ack %b want 1", bus.oAck); end
        tick();
    endtask

    task automatic test_full_pop();
        bus.iWr_En = 1'b1; bus.iData_A = 32'h11; bus.iData_B = 32'h12;
        tick();
        bus.iWr_En = 1'b0;
        tick();
        tick();
        for (int k = 1; k <= 4; k++) begin
            bus.iWr_En = 1'b1; bus.iData_A = 32'(100 + k); bus.iData_B = 32'(200 + k);
            tick();
        end
        bus.iWr_En = 1'b0;
        tests_run++; if (bus.oCount !== 3'd4 || bus.oFull !== 1'b1 || bus.oOverflow !== 1'b0) begin tests_failed++; $display("FAIL fp_filled: count %0d full %b ovf %b want 4 1 0", bus.oCount, bus.oFull, bus.oOverflow); end
        bus.iDone = 1'b1;
        tick();
        bus.iDone = 1'b0;
        tick();
        bus.iWr_En = 1'b1; bus.iData_A = 32'hDEAD; bus.iData_B = 32'hBEEF;
        tick();
        bus.iWr_En = 1'b0;
        tests_run++; if (bus.oCount !== 3'd3 || bus.oFull !== 1'b0 || bus.oOverflow !== 1'b1) begin tests_failed++; $display("FAIL fp_drop: count %0d full %b ovf %b want 3 0 1", bus.oCount, bus.oFull, bus.oOverflow); end
        tests_run++; if (bus.oValid_Data !== 1'b1 || bus.oData_A !== 32'd101 || bus.oData_B !== 32'd201) begin tests_failed++; $display("FAIL fp_issue: valid %b A %0d B %0d want 1 101 201", bus.oValid_Data, bus.oData_A, bus.oData_B); end
        tick();
        bus.iDone = 1'b1;
        tick();
        bus.iDone = 1'b0;
        tick();
        tick();
        tests_run++; if (bus.oData_A !== 32'd102 || bus.oCount !== 3'd2) begin tests_failed++; $display("FAIL fp_next: A %0d count %0d want 102 2", bus.oData_A, bus.oCount); end
        tick();
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if ({bus.oValid_Data, bus.oAck, bus.oBusy, bus.oFull, bus.oOverflow, bus.oTimeout} !== 6'b0) begin tests_failed++; $display("FAIL mid_flags: got %b want 000000", {bus.oValid_Data, bus.oAck, bus.oBusy, bus.oFull, bus.oOverflow, bus.oTimeout}); end
        tests_run++; if (bus.oCount !== 3'd0 || {bus.oData_A, bus.oData_B} !== 64'd0) begin tests_failed++; $display("FAIL mid_state: count %0d data %h want 0 0", bus.oCount, {bus.oData_A, bus.oData_B}); end
        for (int i = 0; i < 3; i++) begin
            bus.iDone = 1'b1;
            tick();
            tests_run++; if (bus.oAck !== 1'b0) begin tests_failed++; $display("FAIL mid_noack%0d: got %b want 0", i, bus.oAck); end
        end
        bus.iDone = 1'b0;
        rst_n = 1'b1;
        bus.iWr_En = 1'b1; bus.iData_A = 32'h55; bus.iData_B = 32'h66;
        tick();
        bus.iWr_En = 1'b0;
        tests_run++; if (bus.oCount !== 3'd1) begin tests_failed++; $display("FAIL mid_push: count %0d want 1", bus.oCount); end
        tick();
        tests_run++; if (bus.oValid_Data !== 1'b1 || bus.oData_A !== 32'h55 || bus.oData_B !== 32'h66) begin tests_failed++; $display("FAIL mid_issue: valid %b A %h B %h want 1 55 66", bus.oValid_Data, bus.oData_A, bus.oData_B); end
        tick();
        bus.iDone = 1'b1;
        tick();
        bus.iDone = 1'b0;
        tests_run++; if (bus.oAck !== 1'b1) begin tests_failed++; $display("FAIL mid_ack: got %b want 1", bus.oAck); end
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.iWr_En   = 1'b0;
        bus.iData_A  = 32'd0;
        bus.iData_B  = 32'd0;
        bus.iDone    = 1'b0;
        bus.iClr_Err = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_timeout_race();
        test_done_ignored();
        test_full_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
